// File: rtl/sram_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified SRAM.
// slave is the arbiter's view; master is the requester/memory side.
interface sram_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic        dm_unsigned;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;

  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata, dm_err,
    output sram_w_en, sram_address, sram_write_data,
    input  sram_read_data
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata, dm_err,
    input  sram_w_en, sram_address, sram_write_data,
    output sram_read_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer sharing one byte-addressed SRAM between
// instruction fetch and data ports, with load extension, alignment checks and wait states.
module sram_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);
  localparam int CW = 4;

  typedef enum logic { IDLE, ACCESS } state_t;
  typedef enum logic { OWN_IF, OWN_DM } owner_t;

  typedef struct packed {
    owner_t      owner;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic [15:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t        state;
  owner_t        last_grant;
  req_t          cur;
  logic [CW-1:0] cnt;

  logic          grant_if, grant_dm;
  logic          dm_mis;
  logic          last;
  logic [3:0]    lanes;
  logic [31:0]   ext;

  logic          if_rvalid_q, dm_rvalid_q, dm_err_q;
  logic [31:0]   if_rdata_q, dm_rdata_q;

  // Arbitration only happens in IDLE; on a tie the port that did not win last time goes.
  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (!rst && state == IDLE) begin
      if (bus.dm_req && (!bus.if_req || last_grant == OWN_IF)) grant_dm = 1'b1;
      else if (bus.if_req)                                     grant_if = 1'b1;
    end
  end

  always_comb begin
    case (bus.dm_size)
      2'b00:   dm_mis = 1'b0;
      2'b01:   dm_mis = bus.dm_addr[0];
      2'b10:   dm_mis = |bus.dm_addr[1:0];
      default: dm_mis = 1'b1;
    endcase
  end

  assign last = (state == ACCESS) && (cnt == '0);

  always_comb begin
    case (cur.size)
      2'b00:   lanes = 4'b0001;
      2'b01:   lanes = 4'b0011;
      2'b10:   lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  always_comb begin
    case (cur.size)
      2'b00:   ext = {{24{~cur.uns & bus.sram_read_data[7]}},  bus.sram_read_data[7:0]};
      2'b01:   ext = {{16{~cur.uns & bus.sram_read_data[15]}}, bus.sram_read_data[15:0]};
      default: ext = bus.sram_read_data;
    endcase
    if (cur.err || cur.we) ext = '0;
  end

  // rst gates the write strobe combinationally so a reset landing on the final
  // access cycle cannot commit a store.
  assign bus.sram_w_en       = (last && cur.we && !cur.err && !rst) ? lanes : 4'b0000;
  assign bus.sram_write_data = (last && !rst) ? cur.wdata : '0;
  assign bus.sram_address    = (state == ACCESS) ? cur.addr : '0;

  assign bus.if_gnt    = grant_if;
  assign bus.dm_gnt    = grant_dm;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_err    = dm_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= OWN_IF;
      cur         <= '0;
      cnt         <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            cur <= '{owner: OWN_DM, we: bus.dm_we, size: bus.dm_size, uns: bus.dm_unsigned,
                     err: dm_mis, addr: bus.dm_addr, wdata: bus.dm_wdata};
            last_grant <= OWN_DM;
            cnt        <= CW'(WAIT_STATES);
            state      <= ACCESS;
          end else if (grant_if) begin
            cur <= '{owner: OWN_IF, we: 1'b0, size: 2'b10, uns: 1'b0,
                     err: 1'b0, addr: bus.if_addr, wdata: 32'h0};
            last_grant <= OWN_IF;
            cnt        <= CW'(WAIT_STATES);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state <= IDLE;
            if (cur.owner == OWN_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.sram_read_data;
            end else begin
              dm_rvalid_q <= 1'b1;
              dm_err_q    <= cur.err;
              dm_rdata_q  <= ext;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: two instances (0 and 2 wait states), byte-array SRAM
// models, and a response scoreboard popped by per-instance monitors.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst0, rst2;
  always #5 clk = ~clk;

  sram_arbiter_if a0();
  sram_arbiter_if a2();

  sram_arbiter #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst0), .bus(a0.slave));
  sram_arbiter #(.WAIT_STATES(2)) dut2 (.clk(clk), .rst(rst2), .bus(a2.slave));

  logic [7:0] mem0 [65536];
  logic [7:0] mem2 [65536];
  logic [15:0] r0a0, r0a1, r0a2, r0a3, r2a0, r2a1, r2a2, r2a3;

  assign r0a0 = a0.sram_address;
  assign r0a1 = a0.sram_address + 16'd1;
  assign r0a2 = a0.sram_address + 16'd2;
  assign r0a3 = a0.sram_address + 16'd3;
  assign r2a0 = a2.sram_address;
  assign r2a1 = a2.sram_address + 16'd1;
  assign r2a2 = a2.sram_address + 16'd2;
  assign r2a3 = a2.sram_address + 16'd3;
  assign a0.sram_read_data = {mem0[r0a3], mem0[r0a2], mem0[r0a1], mem0[r0a0]};
  assign a2.sram_read_data = {mem2[r2a3], mem2[r2a2], mem2[r2a1], mem2[r2a0]};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (a0.sram_w_en[i]) mem0[a0.sram_address + 16'(i)] <= a0.sram_write_data[8*i +: 8];
      if (a2.sram_w_en[i]) mem2[a2.sram_address + 16'(i)] <= a2.sram_write_data[8*i +: 8];
    end
  end

  typedef struct { logic dm; logic [31:0] data; logic err; } exp_t;
  exp_t sb0[$];
  exp_t sb2[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wen_hits = 0;
  int wen_cyc = -1;
  logic [3:0] wen_last = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (|a0.sram_w_en) begin
      wen_hits++;
      wen_last = a0.sram_w_en;
      wen_cyc  = cyc;
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (a0.if_rvalid || a0.dm_rvalid) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected_rvalid if=%b dm=%b expected none", a0.if_rvalid, a0.dm_rvalid);
      end else begin
        e = sb0.pop_front();
        chk("d0_rsp_port", {31'b0, a0.dm_rvalid}, {31'b0, e.dm});
        chk("d0_rsp_both", {31'b0, a0.if_rvalid & a0.dm_rvalid}, 32'd0);
        if (e.dm) begin
          chk("d0_dm_rdata", a0.dm_rdata, e.data);
          chk("d0_dm_err", {31'b0, a0.dm_err}, {31'b0, e.err});
        end else begin
          chk("d0_if_rdata", a0.if_rdata, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (a2.if_rvalid || a2.dm_rvalid) begin
      if (sb2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2_unexpected_rvalid if=%b dm=%b expected none", a2.if_rvalid, a2.dm_rvalid);
      end else begin
        e = sb2.pop_front();
        chk("d2_rsp_port", {31'b0, a2.dm_rvalid}, {31'b0, e.dm});
        if (e.dm) begin
          chk("d2_dm_rdata", a2.dm_rdata, e.data);
          chk("d2_dm_err", {31'b0, a2.dm_err}, {31'b0, e.err});
        end else begin
          chk("d2_if_rdata", a2.if_rdata, e.data);
        end
      end
    end
  end

  task automatic dm_op(input logic we, input logic [1:0] sz, input logic uns, input logic [15:0] ad,
                       input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                       output int gc, output int rc);
    int n;
    gc = -1; rc = -1;
    sb0.push_back('{1'b1, ed, ee});
    @(posedge clk); #1;
    a0.dm_req = 1'b1; a0.dm_we = we; a0.dm_size = sz; a0.dm_unsigned = uns;
    a0.dm_addr = ad; a0.dm_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!a0.dm_gnt && n < 20) begin @(negedge clk); n++; end
    if (a0.dm_gnt) gc = cyc;
    @(posedge clk); #1 a0.dm_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a0.dm_rvalid && n < 20) begin @(negedge clk); n++; end
    if (a0.dm_rvalid) rc = cyc;
    chk("dm_op_completed", {31'b0, (gc >= 0 && rc >= 0)}, 32'd1);
  endtask

  task automatic if_op(input logic [15:0] ad, input logic [31:0] ed);
    int n;
    logic ok;
    sb0.push_back('{1'b0, ed, 1'b0});
    @(posedge clk); #1;
    a0.if_req = 1'b1; a0.if_addr = ad;
    n = 0;
    @(negedge clk);
    while (!a0.if_gnt && n < 20) begin @(negedge clk); n++; end
    ok = a0.if_gnt;
    @(posedge clk); #1 a0.if_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a0.if_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("if_op_completed", {31'b0, ok & a0.if_rvalid}, 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gc, rc, h, n;
    a0.if_req = 0; a0.if_addr = 0; a0.dm_req = 0; a0.dm_we = 0; a0.dm_size = 0;
    a0.dm_unsigned = 0; a0.dm_addr = 0; a0.dm_wdata = 0;
    a2.if_req = 0; a2.if_addr = 0; a2.dm_req = 0; a2.dm_we = 0; a2.dm_size = 0;
    a2.dm_unsigned = 0; a2.dm_addr = 0; a2.dm_wdata = 0;
    rst0 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0; rst2 = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_sram_w_en", {28'b0, a0.sram_w_en}, 32'd0);
    chk("rst_sram_address", {16'b0, a0.sram_address}, 32'd0);
    chk("rst_sram_wdata", a0.sram_write_data, 32'd0);
    chk("rst_rvalids", {30'b0, a0.if_rvalid, a0.dm_rvalid}, 32'd0);
    chk("rst_rdata", a0.if_rdata | a0.dm_rdata, 32'd0);
    chk("rst_gnts", {30'b0, a0.if_gnt, a0.dm_gnt}, 32'd0);

    // test 1: word store then fetch
    dm_op(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, gc, rc);
    chk("t1_wen_value", {28'b0, wen_last}, 32'hF);
    chk("t1_wen_cycle", wen_cyc, gc + 1);
    chk("t1_rvalid_cycle", rc, gc + 2);
    if_op(16'h0010, 32'hDEADBEEF);

    // test 2: sub-word loads
    dm_op(1'b0, 2'b00, 1'b0, 16'h0013, 32'h0, 32'hFFFFFFDE, 1'b0, gc, rc);
    dm_op(1'b0, 2'b00, 1'b1, 16'h0013, 32'h0, 32'h000000DE, 1'b0, gc, rc);
    dm_op(1'b0, 2'b01, 1'b0, 16'h0012, 32'h0, 32'hFFFFDEAD, 1'b0, gc, rc);
    dm_op(1'b0, 2'b01, 1'b1, 16'h0010, 32'h0, 32'h0000BEEF, 1'b0, gc, rc);
    if_op(16'h0011, 32'h00DEADBE & 32'h00FFFFFF | {mem0[16'h0014], 24'h0});
    chk("t2_dm_rdata_held", a0.dm_rdata, 32'h0000BEEF);

    // test 3: misaligned / illegal stores are suppressed
    h = wen_hits;
    dm_op(1'b1, 2'b01, 1'b0, 16'h0011, 32'h0000AAAA, 32'h0, 1'b1, gc, rc);
    dm_op(1'b1, 2'b11, 1'b0, 16'h0020, 32'h12345678, 32'h0, 1'b1, gc, rc);
    chk("t3_no_write", wen_hits, h);
    dm_op(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, gc, rc);

    // test 4: both requesting from reset
    @(posedge clk); #1;
    rst0 = 1'b1;
    a0.if_req = 1'b1; a0.if_addr = 16'h0010;
    a0.dm_req = 1'b1; a0.dm_we = 1'b0; a0.dm_size = 2'b10; a0.dm_unsigned = 1'b0; a0.dm_addr = 16'h0010;
    sb0.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    sb0.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    sb0.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    sb0.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    @(posedge clk); #1 rst0 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("t4_dm_gnt_c%0d", k), {31'b0, a0.dm_gnt}, {31'b0, (k % 4 == 0)});
      chk($sformatf("t4_if_gnt_c%0d", k), {31'b0, a0.if_gnt}, {31'b0, (k % 4 == 2)});
      @(posedge clk); #1;
    end
    a0.if_req = 1'b0; a0.dm_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_sb_drained", sb0.size(), 0);

    // test 5: two wait states, byte store
    sb2.push_back('{1'b1, 32'h0, 1'b0});
    @(posedge clk); #1;
    a2.dm_req = 1'b1; a2.dm_we = 1'b1; a2.dm_size = 2'b00; a2.dm_unsigned = 1'b0;
    a2.dm_addr = 16'h0100; a2.dm_wdata = 32'h0000005A;
    @(negedge clk);
    chk("t5_gnt", {31'b0, a2.dm_gnt}, 32'd1);
    @(posedge clk); #1 a2.dm_req = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5_wen_c%0d", c), {28'b0, a2.sram_w_en}, (c == 3) ? 32'h1 : 32'h0);
      chk($sformatf("t5_addr_c%0d", c), {16'b0, a2.sram_address}, (c <= 3) ? 32'h0100 : 32'h0);
      chk($sformatf("t5_rvalid_c%0d", c), {31'b0, a2.dm_rvalid}, {31'b0, (c == 4)});
      if (c < 4) begin @(posedge clk); #1; end
    end
    chk("t5_mem", {24'b0, mem2[16'h0100]}, 32'h5A);

    // test 6: reset on the final access cycle of a store
    @(posedge clk); #1;
    a0.dm_req = 1'b1; a0.dm_we = 1'b1; a0.dm_size = 2'b10; a0.dm_addr = 16'h0010; a0.dm_wdata = 32'h12345678;
    @(negedge clk);
    chk("t6_gnt", {31'b0, a0.dm_gnt}, 32'd1);
    @(posedge clk); #1 rst0 = 1'b1; a0.dm_req = 1'b0;
    @(negedge clk);
    chk("t6_wen_in_rst", {28'b0, a0.sram_w_en}, 32'd0);
    @(posedge clk); #1 rst0 = 1'b0;
    @(negedge clk);
    chk("t6_rvalids", {30'b0, a0.if_rvalid, a0.dm_rvalid}, 32'd0);
    chk("t6_outputs", {a0.sram_address, 12'b0, a0.sram_w_en}, 32'd0);
    chk("t6_rdata", a0.if_rdata | a0.dm_rdata, 32'd0);
    chk("t6_mem", {mem0[16'h0013], mem0[16'h0012], mem0[16'h0011], mem0[16'h0010]}, 32'hDEADBEEF);
    sb0.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    sb0.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    @(posedge clk); #1;
    a0.dm_req = 1'b1; a0.dm_we = 1'b0; a0.dm_size = 2'b10; a0.dm_unsigned = 1'b1; a0.dm_addr = 16'h0010;
    a0.if_req = 1'b1; a0.if_addr = 16'h0010;
    @(negedge clk);
    chk("t6_dm_wins", {30'b0, a0.dm_gnt, a0.if_gnt}, 32'b10);
    @(posedge clk); #1 a0.dm_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!a0.if_gnt && n < 20) begin @(negedge clk); n++; end
    chk("t6_if_gnt_later", {31'b0, a0.if_gnt}, 32'd1);
    @(posedge clk); #1 a0.if_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_sb0_drained", sb0.size(), 0);
    chk("final_sb2_drained", sb2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter and access sequencer for the byte-addressed 64 KiB unified SRAM (16-bit byte address, 4-bit byte-lane write enable, combinational 32-bit little-endian read).
- Shares the SRAM between the instruction-fetch port (IF, word reads only) and the data port (DM, byte/half/word loads and stores).
- Generates lane enables, sign/zero-extends loads, rejects misaligned data accesses.
- Inserts programmable wait states to model slower memory.

Parameters:
- WAIT_STATES, 0, extra ACCESS cycles per transfer (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; hold with if_addr stable until if_gnt
- if_addr  in  16  fetch byte address (word access)
- if_gnt  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  32  fetched word
- dm_req  in  1  data request; hold all dm_* inputs stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
- dm_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- dm_addr  in  16  data byte address
- dm_wdata  in  32  store data, right-aligned
- dm_gnt  out  1  data request accepted (1-cycle pulse)
- dm_rvalid  out  1  load data valid / store complete (1-cycle pulse)
- dm_rdata  out  32  extended load data; 0 for stores and errors
- dm_err  out  1  qualifies dm_rvalid: misaligned/illegal, access suppressed
- sram_w_en  out  4  to SRAM byte-lane write enable
- sram_address  out  16  to SRAM address
- sram_write_data  out  32  to SRAM write data
- sram_read_data  in  32  from SRAM combinational read data

Behaviour:
- Clock/reset: one clock, clk. rst is synchronous, active-high.
- Reset values: all outputs 0; FSM in IDLE; last_grant = IF, so DM wins the first conflict.
- FSM states: IDLE, ACCESS.
- IDLE, no request: stay in IDLE.
- IDLE, single request: that requester wins.
- IDLE, both requesting: grant goes to the requester not in last_grant (round-robin).
- IDLE, on grant:
  - pulse the winner's gnt that cycle;
  - latch owner, addr, we, size, unsigned, wdata (IF latches we=0, size=10);
  - load cnt = WAIT_STATES; update last_grant; go to ACCESS.
- ACCESS, every cycle: sram_address = latched addr.
- ACCESS, last cycle (cnt==0):
  - drive sram_w_en / sram_write_data;
  - capture response at the rising edge;
  - return to IDLE.
- ACCESS, not last cycle: decrement cnt.
- Latency: gnt in cycle N; SRAM write edge and read capture at end of cycle N+1+WAIT_STATES; rvalid in cycle N+2+WAIT_STATES.
- Throughput: one transfer per WAIT_STATES+2 cycles. The arbiter re-arbitrates in the IDLE cycle that coincides with rvalid.
- Outside ACCESS: sram_w_en=0, sram_address=0, sram_write_data=0.
- In ACCESS before the last cycle: sram_w_en=0.
- Lane enables, last ACCESS cycle, store only:
  - byte: 0001
  - half: 0011
  - word: 1111
- sram_write_data = latched wdata, unmodified.
- Alignment:
  - half requires addr[0]=0;
  - word requires addr[1:0]=00;
  - size 11 is always an error.
- Error response: sram_w_en stays 0 for the whole access; the response is dm_rvalid=1, dm_err=1, dm_rdata=0.
- IF is never alignment-checked: a raw word is read at any address.
- Load extension from sram_read_data:
  - byte: bits[7:0], bit 7 sign-extended unless unsigned;
  - half: bits[15:0], bit 15 sign-extended unless unsigned;
  - word: as-is.
- Address wrap at 0xFFFF is the SRAM's concern; the arbiter passes the address through.
- Response routing: only the owner's rvalid pulses. The other port's rdata holds its last value; rdata registers update only on their own rvalid.
- Requests during ACCESS: ignored, no gnt; the requester holds its request.
- Reset mid-operation: rst in any ACCESS cycle (including the last) forces sram_w_en=0 that cycle, so no write occurs. FSM goes to IDLE, no rvalid is issued, last_grant returns to IF.

Test Plan:
1. WAIT_STATES=0, DM store word 0xDEADBEEF @0x0010, gnt cycle 0 -> sram_w_en=1111 cycle 1, dm_rvalid=1 dm_err=0 cycle 2; then IF fetch @0x0010 -> if_rdata=0xDEADBEEF.
2. Loads after test 1:
   - byte signed @0x0013 -> 0xFFFFFFDE
   - byte unsigned @0x0013 -> 0x000000DE
   - half signed @0x0012 -> 0xFFFFDEAD
   - half unsigned @0x0010 -> 0x0000BEEF
3. Misaligned half store @0x0011, and size=11 @0x0020 -> sram_w_en never nonzero, dm_err=1, dm_rdata=0; a word reread @0x0010 still returns 0xDEADBEEF.
4. Both req held high from reset, WAIT_STATES=0 -> gnts at cycles 0,2,4,6 alternate DM,IF,DM,IF; no gnt in ACCESS cycles 1,3,5.
5. WAIT_STATES=2, DM store byte 0x5A @0x0100 -> gnt cycle 0, sram_w_en=0001 only in cycle 3, dm_rvalid cycle 4; sram_address=0x0100 in cycles 1-3.
6. rst asserted in the last ACCESS cycle of a word store -> no write (memory unchanged), no rvalid, outputs 0 next cycle; the next simultaneous request grants DM.
